// File: rtl/shift_reg_sequencer_if.sv
// Host-side command/response channel of shift_reg_sequencer.
// The host drives the master side; the sequencer uses the slave side.
interface shift_reg_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register: load, shift 4 bits out/in, respond.
// Optional abort input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_reg_sequencer #(
  parameter int CLK_DIV = 1
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic                        abort,
`endif
  shift_reg_sequencer_if.slave        bus,
  output logic                        busy,
  output logic                        tx_bit,
  input  logic                        rx_bit,
  output logic [1:0]                  sr_sel,
  output logic [3:0]                  sr_inp,
  output logic                        sr_serial_in,
  input  logic [3:0]                  sr_out
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam bit              DIV_BY_ONE = (CLK_DIV == 1);

  state_t           state_q;
  logic             dir_q;
  logic [3:0]       sr_inp_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [1:0]       bit_cnt_q;
  logic [1:0]       sr_sel_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic       abort_req;
  logic       strobe;
  logic [1:0] shift_sel;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign strobe    = (state_q == SHIFT) && (div_cnt_q == '0);
  assign shift_sel = dir_q ? SEL_RIGHT : SEL_LEFT;

  // sr_sel is registered, so each transition selects the mode of the *next* cycle:
  // a strobe is pending next cycle when the divider is about to reach zero.
  // NOTE: every state register updates with <= so all of them see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      sr_inp_q    <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_sel_q    <= SEL_HOLD;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= LOAD;
            dir_q       <= bus.cmd_dir;
            sr_inp_q    <= bus.cmd_data;
            sr_sel_q    <= SEL_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (abort_req) begin
            state_q     <= IDLE;
            sr_sel_q    <= SEL_HOLD;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q   <= SHIFT;
            div_cnt_q <= DIV_RELOAD;
            bit_cnt_q <= '0;
            sr_sel_q  <= DIV_BY_ONE ? shift_sel : SEL_HOLD;
          end
        end
        SHIFT: begin
          if (abort_req) begin
            state_q     <= IDLE;
            sr_sel_q    <= SEL_HOLD;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (strobe) begin
            bit_cnt_q <= bit_cnt_q + 2'd1;
            div_cnt_q <= DIV_RELOAD;
            if (bit_cnt_q == 2'd3) begin
              state_q     <= RESP;
              sr_sel_q    <= SEL_HOLD;
              rsp_valid_q <= 1'b1;
            end else begin
              sr_sel_q <= DIV_BY_ONE ? shift_sel : SEL_HOLD;
            end
          end else begin
            div_cnt_q <= div_cnt_q - DIV_ONE;
            sr_sel_q  <= (div_cnt_q == DIV_ONE) ? shift_sel : SEL_HOLD;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Serial and response data follow the external register directly; it only moves on strobes.
  assign tx_bit        = (state_q == SHIFT) ? (dir_q ? sr_out[0] : sr_out[3]) : 1'b0;
  assign bus.rsp_data  = (state_q == RESP) ? sr_out : 4'h0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign busy          = busy_q;
  assign sr_sel        = sr_sel_q;
  assign sr_inp        = sr_inp_q;
  assign sr_serial_in  = rx_bit;

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller that sequences the team's 4-bit universal shift register, which has hold, shift-left, shift-right and parallel-load modes. For each accepted command it:
- parallel-loads a 4-bit word into the register;
- clocks the word out serially on `tx_bit` while capturing `rx_bit` into the vacated positions;
- returns the received 4-bit word on a valid/ready response channel.

It sits between a host-side command interface and the shift register's `sel`/`inp`/`serial_in`/`out` pins, and owns all mode selection.

## Interface
- `CLK_DIV`, default 1: clocks per shift strobe; legal range 1..256.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; also drives the shift register's reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_dir`  in  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
- `cmd_data`  in  4  word to transmit.
- `rsp_valid`  out  1  received word available.
- `rsp_ready`  in  1  host accepts response.
- `rsp_data`  out  4  received word.
- `busy`  out  1  high in any state other than IDLE.
- `tx_bit`  out  1  serial output.
- `rx_bit`  in  1  serial input.
- `sr_sel`  out  2  to register `sel`: 00 hold, 01 left, 10 right, 11 load.
- `sr_inp`  out  4  to register `inp`.
- `sr_serial_in`  out  1  to register `serial_in`.
- `sr_out`  in  4  from register `out`.

## Operation
States are IDLE, LOAD, SHIFT and RESP.

IDLE
- `cmd_ready`=1, `sr_sel`=00.
- `cmd_valid`&`cmd_ready` at a rising edge: latch `cmd_data` and `cmd_dir`, then go to LOAD.

LOAD (1 cycle)
- `sr_sel`=11, `sr_inp`=latched data; the register loads at the end of this cycle.
- Clear `div_cnt` to `CLK_DIV`-1 and `bit_cnt` to 0, then go to SHIFT.

SHIFT
- `div_cnt` decrements each cycle. A strobe occurs in a cycle where `div_cnt`==0.
- Strobe cycle: `sr_sel`=01 (dir 0) or 10 (dir 1), `bit_cnt`+1, `div_cnt` reloads `CLK_DIV`-1.
- Non-strobe cycle: `sr_sel`=00.
- Go to RESP after the strobe with `bit_cnt`==3, i.e. after the 4th shift.

RESP
- `sr_sel`=00, `rsp_valid`=1, `rsp_data`=`sr_out`, held stable.
- `rsp_valid`&`rsp_ready` at an edge: go to IDLE.

Serial paths and data rules
- `tx_bit` = `sr_out[3]` (dir 0) or `sr_out[0]` (dir 1) while in SHIFT; 0 otherwise. The departing bit is valid for the whole strobe interval.
- `sr_serial_in` = `rx_bit`, combinational pass-through; sampled by the register on strobe edges only.
- Dir 0: first rx bit ends in `sr_out[3]`, last in `sr_out[0]`.
- Dir 1: first rx bit ends in `sr_out[0]`, last in `sr_out[3]`.
- `cmd_data` is ignored outside IDLE.
- Commands are not accepted in RESP, even when `rsp_ready` is high in the same cycle; the new command is taken in the following IDLE cycle.

Reset
- `reset` asserted at any time forces IDLE immediately: `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `tx_bit`=0, `sr_sel`=00, `sr_inp`=0, counters 0.
- Any in-flight transfer is discarded.

## Timing
- Command accepted at edge E0. LOAD occupies cycle E0..E1.
- Shift k (k=1..4) happens at edge E1+k·`CLK_DIV`.
- `rsp_valid` rises right after edge E1+4·`CLK_DIV`. With `CLK_DIV`=1 this is 5 cycles after acceptance.
- Minimum command-to-command spacing is 4·`CLK_DIV`+3 cycles: LOAD, the shift cycles, one RESP cycle and one IDLE cycle.
- `rsp_data` and `rsp_valid` remain stable under backpressure for as many cycles as `rsp_ready` stays low.

## Configuration
- `SHIFT_SEQ_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort`=1 at an edge in LOAD or SHIFT: go to IDLE, with `sr_sel`=00 from the next cycle.
  - No response is produced and register contents are left as-is.
  - `abort` is ignored in IDLE and RESP.
- Undefined: the port is absent and every accepted command runs to a response.

## Test plan
- `CLK_DIV`=1, dir 0, `cmd_data`=4'b1011, `rx_bit` sequence 0,1,1,0:
  - `tx_bit` sequence 1,0,1,1 on the four shift cycles;
  - `rsp_valid` 5 cycles after accept, `rsp_data`=4'b0110.
- `CLK_DIV`=3, dir 1, `cmd_data`=4'b0001, `rx_bit` held 1:
  - `tx_bit` 1,0,0,0, each held for 3 cycles;
  - `sr_sel`=10 exactly once per 3 cycles;
  - `rsp_data`=4'b1111 at cycle 13.
- `rsp_ready` held low 10 cycles in RESP:
  - `rsp_valid` and `rsp_data` stable and `cmd_ready`=0 throughout;
  - `cmd_valid` held high is accepted one cycle after the handshake.
- `reset` pulsed asynchronously mid-SHIFT (after 2 shifts):
  - outputs reach reset values without waiting for a clock edge;
  - the next command completes normally with correct data.
- With `SHIFT_SEQ_ABORT_EN`, `abort` after 1 shift:
  - IDLE next cycle, no `rsp_valid`, `cmd_ready`=1.
- Back-to-back commands 4'hA then 4'h5 with `rsp_ready`=1, `rx_bit`=0:
  - responses 4'h0, 4'h0;
  - second LOAD starts 1 cycle after the first RESP handshake.
